// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, IF/ID register, hold buffer for decode stalls.
// Build macro IF_BRANCH_DELAY_SLOT_EN: defined keeps IF/ID on ex_redirect (delay slot), undefined bubbles it.
module instruction_fetch_stage (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_request,
  output logic [31:0] imem_address,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  input  logic        id_shouldStall,
  input  logic        ex_redirect,
  input  logic [31:0] ex_redirectTarget,
  output logic [31:0] id_pc_4,
  output logic [31:0] id_instruction,
  output logic        debugState
);

  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

`ifdef IF_BRANCH_DELAY_SLOT_EN
  localparam bit FlushToBubble = 1'b0;
`else
  localparam bit FlushToBubble = 1'b1;
`endif

  state_t      state, stateNext;
  logic [31:0] pc, pcNext;
  logic [31:0] holdBuffer, holdBufferNext;
  logic        pending, pendingNext;
  logic [31:0] pendingTarget, pendingTargetNext;
  logic [31:0] idPc4Next, idInstructionNext;
  logic [31:0] pcPlus4;

  assign pcPlus4 = pc + 32'd4;

  // Handshake: imem_request/imem_address hold steady until a cycle with imem_ready=1,
  // in which imem_data is valid and the request completes; requests are never withdrawn.
  assign imem_request = (state == FETCH) && !reset;
  assign imem_address = pc;
  assign debugState   = (state == HOLD);

  always_comb begin
    stateNext         = state;
    pcNext            = pc;
    holdBufferNext    = holdBuffer;
    pendingNext       = pending;
    pendingTargetNext = pendingTarget;
    idPc4Next         = id_pc_4;
    idInstructionNext = id_instruction;

    case (state)
      FETCH: begin
        if (ex_redirect) begin
          if (imem_ready) begin
            pcNext      = ex_redirectTarget;
            pendingNext = 1'b0;
          end else begin
            pendingNext       = 1'b1;
            pendingTargetNext = ex_redirectTarget;
          end
        end else if (imem_ready && pending) begin
          // Word belongs to the abandoned path: drop it and resume at the latched target.
          pcNext      = pendingTarget;
          pendingNext = 1'b0;
          if (!id_shouldStall) begin
            idInstructionNext = 32'd0;
            idPc4Next         = 32'd0;
          end
        end else if (imem_ready && !id_shouldStall) begin
          idInstructionNext = imem_data;
          idPc4Next         = pcPlus4;
          pcNext            = pcPlus4;
        end else if (imem_ready) begin
          holdBufferNext = imem_data;
          stateNext      = HOLD;
        end else if (!id_shouldStall) begin
          idInstructionNext = 32'd0;
          idPc4Next         = 32'd0;
        end
      end
      HOLD: begin
        if (ex_redirect) begin
          holdBufferNext = 32'd0;
          pendingNext    = 1'b0;
          pcNext         = ex_redirectTarget;
          stateNext      = FETCH;
        end else if (!id_shouldStall) begin
          idInstructionNext = holdBuffer;
          idPc4Next         = pcPlus4;
          pcNext            = pcPlus4;
          holdBufferNext    = 32'd0;
          stateNext         = FETCH;
        end
      end
      default: stateNext = FETCH;
    endcase

    // Redirect flush wins over a decode stall.
    if (ex_redirect && FlushToBubble) begin
      idInstructionNext = 32'd0;
      idPc4Next         = 32'd0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= FETCH;
      pc             <= 32'd0;
      holdBuffer     <= 32'd0;
      pending        <= 1'b0;
      pendingTarget  <= 32'd0;
      id_pc_4        <= 32'd0;
      id_instruction <= 32'd0;
    end else begin
      state          <= stateNext;
      pc             <= pcNext;
      holdBuffer     <= holdBufferNext;
      pending        <= pendingNext;
      pendingTarget  <= pendingTargetNext;
      id_pc_4        <= idPc4Next;
      id_instruction <= idInstructionNext;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed scenarios plus randomized traffic against a queue-based
// reference model; a monitor pops expected outputs each cycle and compares.
module tb_instruction_fetch_stage;

  localparam int W = 97;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imem_request;
  logic [31:0] imem_address;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_data = 32'd0;
  logic        id_shouldStall = 1'b0;
  logic        ex_redirect = 1'b0;
  logic [31:0] ex_redirectTarget = 32'd0;
  logic [31:0] id_pc_4;
  logic [31:0] id_instruction;
  logic        debugState;

  instruction_fetch_stage dut (
    .clock(clock), .reset(reset),
    .imem_request(imem_request), .imem_address(imem_address),
    .imem_ready(imem_ready), .imem_data(imem_data),
    .id_shouldStall(id_shouldStall),
    .ex_redirect(ex_redirect), .ex_redirectTarget(ex_redirectTarget),
    .id_pc_4(id_pc_4), .id_instruction(id_instruction),
    .debugState(debugState)
  );

  // clock / reset
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  // reference model: hold buffer and pending redirect are queues of at most one entry
  logic [31:0] mPc, mInst, mPc4;
  logic [31:0] mHold[$];
  logic [31:0] mRedir[$];

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[31:2] ^ 30'h2A5A5A5, 2'b11};
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mPc = 32'd0; mInst = 32'd0; mPc4 = 32'd0;
    mHold.delete();
    mRedir.delete();
  endtask

  task automatic modelFlush();
`ifndef IF_BRANCH_DELAY_SLOT_EN
    mInst = 32'd0; mPc4 = 32'd0;
`endif
  endtask

  task automatic modelStep(input logic rdy, input logic [31:0] data, input logic stl,
                           input logic rd, input logic [31:0] tgt);
    if (mHold.size() != 0) begin
      if (rd) begin
        mHold.delete(); mPc = tgt; modelFlush();
      end else if (!stl) begin
        mInst = mHold.pop_front(); mPc4 = mPc + 32'd4; mPc = mPc + 32'd4;
      end
    end else begin
      if (rd) begin
        modelFlush();
        mRedir.delete();
        if (rdy) mPc = tgt;
        else mRedir.push_back(tgt);
      end else if (rdy && mRedir.size() != 0) begin
        mPc = mRedir.pop_front();
        if (!stl) begin mInst = 32'd0; mPc4 = 32'd0; end
      end else if (rdy && !stl) begin
        mInst = data; mPc4 = mPc + 32'd4; mPc = mPc + 32'd4;
      end else if (rdy) begin
        mHold.push_back(data);
      end else if (!stl) begin
        mInst = 32'd0; mPc4 = 32'd0;
      end
    end
  endtask

  // driver: apply one cycle of inputs and queue the outputs expected after the next edge
  task automatic doCycle(input logic rdy, input logic [31:0] data, input logic stl,
                         input logic rd, input logic [31:0] tgt);
    @(negedge clock);
    imem_ready = rdy; imem_data = data; id_shouldStall = stl;
    ex_redirect = rd; ex_redirectTarget = tgt;
    modelStep(rdy, data, stl, rd, tgt);
    exp_q.push_back({mHold.size() == 0, mPc, mInst, mPc4});
  endtask

  task automatic fetchRun(input int n);
    for (int i = 0; i < n; i++) doCycle(1'b1, memWord(mPc), 1'b0, 1'b0, 32'd0);
  endtask

  task automatic settle();
    @(posedge clock);
    #2;
  endtask

  task automatic doReset();
    settle();
    reset = 1'b1;
    #1;
    check32("rst_req", {31'd0, imem_request}, 32'd0);
    check32("rst_addr", imem_address, 32'd0);
    check32("rst_inst", id_instruction, 32'd0);
    check32("rst_pc4", id_pc_4, 32'd0);
    @(negedge clock);
    imem_ready = 1'b0; id_shouldStall = 1'b0; ex_redirect = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    modelReset();
    #1;
    check32("rel_req", {31'd0, imem_request}, 32'd1);
    check32("rel_addr", imem_address, 32'd0);
  endtask

  // monitor
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check32("mon_req", {31'd0, imem_request}, {31'd0, e[96]});
        check32("mon_addr", imem_address, e[95:64]);
        check32("mon_inst", id_instruction, e[63:32]);
        check32("mon_pc4", id_pc_4, e[31:0]);
      end
    end
  end

  // stimulus
  initial begin
    logic [31:0] expInst;
    logic        rdy, stl, rd;
    logic [31:0] tgt;
    modelReset();
    #1;
    doReset();

    // three back-to-back fetches
    doCycle(1'b1, 32'h11, 1'b0, 1'b0, 32'd0);
    doCycle(1'b1, 32'h22, 1'b0, 1'b0, 32'd0);
    doCycle(1'b1, 32'h33, 1'b0, 1'b0, 32'd0);
    settle();
    check32("seq_inst", id_instruction, 32'h33);
    check32("seq_pc4", id_pc_4, 32'd12);
    check32("seq_addr", imem_address, 32'd12);

    // decode stall while address 8 completes
    doReset();
    fetchRun(2);
    doCycle(1'b1, memWord(32'd8), 1'b1, 1'b0, 32'd0);
    doCycle(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    doCycle(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    settle();
    check32("hold_req", {31'd0, imem_request}, 32'd0);
    check32("hold_inst", id_instruction, memWord(32'd4));
    check32("hold_pc4", id_pc_4, 32'd8);
    doCycle(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    settle();
    check32("unhold_inst", id_instruction, memWord(32'd8));
    check32("unhold_pc4", id_pc_4, 32'd12);
    check32("unhold_addr", imem_address, 32'd12);

    // redirect while request at 0x10 is still waiting
    doReset();
    fetchRun(4);
    doCycle(1'b0, 32'd0, 1'b0, 1'b1, 32'h400);
    settle();
    check32("pend_addr0", imem_address, 32'h10);
    doCycle(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    settle();
    check32("pend_addr1", imem_address, 32'h10);
    doCycle(1'b1, memWord(32'h10), 1'b0, 1'b0, 32'd0);
    settle();
    check32("pend_target", imem_address, 32'h400);
    check32("pend_discard", id_instruction, 32'd0);

    // redirect, ready and stall together at 0x20
    doReset();
    fetchRun(8);
    doCycle(1'b1, memWord(32'h20), 1'b1, 1'b1, 32'h80);
    settle();
`ifdef IF_BRANCH_DELAY_SLOT_EN
    expInst = memWord(32'h1C);
`else
    expInst = 32'd0;
`endif
    check32("rdst_addr", imem_address, 32'h80);
    check32("rdst_inst", id_instruction, expInst);

    // reset while in HOLD
    doReset();
    fetchRun(1);
    doCycle(1'b1, memWord(32'd4), 1'b1, 1'b0, 32'd0);
    doReset();
    doCycle(1'b1, memWord(32'd0), 1'b0, 1'b0, 32'd0);
    settle();
    check32("rst_hold_inst", id_instruction, memWord(32'd0));

    // pc wraps past the top of the address space
    doCycle(1'b1, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    doCycle(1'b1, memWord(32'hFFFF_FFFC), 1'b0, 1'b0, 32'd0);
    settle();
    check32("wrap_pc4", id_pc_4, 32'd0);
    check32("wrap_addr", imem_address, 32'd0);
    check32("wrap_inst", id_instruction, memWord(32'hFFFF_FFFC));

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (c % 700 == 699) doReset();
      rdy = ($urandom_range(0, 9) < 6);
      stl = ($urandom_range(0, 9) < 3);
      rd  = ($urandom_range(0, 99) < 8);
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 + {28'd0, 2'($urandom_range(0, 3)), 2'b00};
      else tgt = $urandom() & 32'hFFFF_FFFC;
      doCycle(rdy, memWord(mPc), stl, rd, tgt);
    end

    settle();
    settle();
    check32("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_stage.md
INSTRUCTION_FETCH_STAGE -- requirements
Module: instruction_fetch_stage

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset: clock in 1 (rising-edge clock); reset in 1 (asynchronous, active-high).
REQ-002 The block SHALL have the following instruction-memory ports: imem_request out 1 (fetch request); imem_address out 32 (fetch address, word-aligned); imem_ready in 1 (fetch complete this cycle); imem_data in 32 (fetched word, valid with imem_ready).
REQ-003 The block SHALL have the following control ports: id_shouldStall in 1 (decode stage cannot accept); ex_redirect in 1 (single-cycle jump/branch-taken pulse); ex_redirectTarget in 32 (new PC, valid with ex_redirect).
REQ-004 The block SHALL have the following decode-stage outputs: id_pc_4 out 32 (fetched PC+4); id_instruction out 32 (fetched word, 0 = bubble/nop).

Function
REQ-005 The block SHALL implement two states: FETCH (request outstanding) and HOLD (word captured, decode stalled).
REQ-006 In FETCH, imem_request SHALL be 1 and imem_address SHALL equal pc.
- imem_address SHALL stay stable until imem_ready; requests are never aborted.
REQ-007 In HOLD, imem_request SHALL be 0.
REQ-008 FETCH with imem_ready=1, id_shouldStall=0, no redirect:
- id_instruction <= imem_data; id_pc_4 <= pc+4; pc <= pc+4; state stays FETCH.
- Sustained throughput: 1 instruction/cycle.
REQ-009 FETCH with imem_ready=1 and id_shouldStall=1: the word SHALL be stored in a hold buffer, with IF/ID unchanged, and the next state SHALL be HOLD.
REQ-010 In HOLD, when id_shouldStall=0: IF/ID SHALL load from the hold buffer, pc <= pc+4, and the next state SHALL be FETCH.
REQ-011 Whenever id_shouldStall=1 and no flush applies, id_instruction and id_pc_4 SHALL hold their values.
REQ-012 FETCH with imem_ready=0 and id_shouldStall=0: IF/ID SHALL load a bubble (id_instruction=0, id_pc_4=0).
REQ-013 ex_redirect in FETCH with imem_ready=0: ex_redirectTarget SHALL be latched and a pending flag set.
- On the later imem_ready, the returned word SHALL be discarded, pc <= latched target, and the flag cleared.
REQ-014 ex_redirect in FETCH with imem_ready=1 in the same cycle: imem_data SHALL be discarded and pc <= ex_redirectTarget.
REQ-015 ex_redirect in HOLD: the hold buffer SHALL be dropped, pc <= ex_redirectTarget, and the next state SHALL be FETCH.
REQ-016 A discarded word SHALL never reach id_instruction; pc arithmetic is modulo 2^32 (0xFFFFFFFC+4 = 0).
REQ-017 The flush applied to IF/ID on ex_redirect SHALL take priority over id_shouldStall.

Reset
REQ-018 Reset SHALL take effect immediately and asynchronously, setting: pc=0x00000000, state=FETCH, pending flag=0, hold buffer=0, id_pc_4=0, id_instruction=0.
REQ-019 While reset is asserted, imem_request SHALL be 0.
- Asserting reset mid-request SHALL drop the request.
- The first request after reset release SHALL issue address 0.

Configuration
REQ-020 The macro IF_BRANCH_DELAY_SLOT_EN SHALL select the redirect behaviour of IF/ID.
- Defined: the IF/ID contents present at ex_redirect SHALL be retained (delay slot executes).
- Undefined: IF/ID SHALL load a bubble on the ex_redirect cycle.
- All other behaviour SHALL be identical in both builds.

Verification
REQ-021 Reset release, memory always ready, words 0x11,0x22,0x33 -> addresses 0,4,8 in consecutive cycles; id_instruction 0x11,0x22,0x33 with id_pc_4 4,8,12.
REQ-022 id_shouldStall=1 for 3 cycles while fetching address 8 (ready) -> HOLD, imem_request=0, IF/ID frozen; after stall release id_instruction=word@8, id_pc_4=12, next address 12.
REQ-023 Redirect to 0x400 while request at 0x10 waits 2 cycles for ready -> address stays 0x10 until ready; that word never appears; next address 0x400.
REQ-024 ex_redirect with imem_ready and id_shouldStall both 1 at pc 0x20, target 0x80 -> next address 0x80; IF/ID bubble (macro undefined) or retained (macro defined).
REQ-025 Reset asserted mid-HOLD -> outputs 0 immediately, imem_request=0; after release, fetch restarts at 0.
REQ-026 pc=0xFFFFFFFC fetched, no stall -> id_pc_4=0x00000000, next address 0x00000000.
